demux2_buf: RTL and testbench
=============================

# demux2_buf

Registered 1-to-2 demultiplexer: the inverse of the 2:1 selector used in the datapath. It accepts one input word per handshake and steers it by `in_sel` into one of two output channels (A when 0, B when 1). Each channel has a one-entry holding register with valid/ready flow control, so a stalled consumer on one channel does not block traffic to the other. It sits between a single producer, such as the ALU result bus, and two consumers, such as the register-file write port and the memory write port.

## Interface
- `WIDTH`, 8: data word width in bits.
- `CNT_W`, 8: width of the per-channel transfer counters (only when `DEMUX2_CNT_EN` is defined).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer presents a word.
- `in_sel`  in  1  destination select: 0 = A, 1 = B. Sampled only while `in_valid` = 1.
- `in_data`  in  WIDTH  input word.
- `in_ready`  out  1  block accepts the word this cycle.
- `a_valid`, `b_valid`  out  1  channel holds a word.
- `a_data`, `b_data`  out  WIDTH  channel word, registered.
- `a_ready`, `b_ready`  in  1  consumer takes the word this cycle.
- `a_cnt`, `b_cnt`  out  CNT_W  accepted-word counters (only when `DEMUX2_CNT_EN` is defined).

## Operation
- Two independent slots, A and B. Each slot has a full flag (drives `x_valid`) and a data register (drives `x_data`).
- Input transfer `acc` = `in_valid & in_ready`.
- Output transfer for channel x = `x_valid & x_ready`.
- `in_ready` = `~full[in_sel] | x_ready[in_sel]`. This is combinational from `in_sel`, the slot state and the selected channel's ready. It never depends on the non-selected channel.
- Per slot x, on each clock:
  - acc to x and no drain: full ← 1, data ← `in_data`.
  - acc to x and drain in the same cycle: full stays 1, data ← `in_data` (pass-through refill, no bubble).
  - drain only: full ← 0, data holds its last value.
  - neither: hold.
- The non-selected slot is never written by an input transfer.
- The block never drops, duplicates or reorders words within a channel. Ordering across channels is not defined.
- `x_data` is held stable while `x_valid` = 1 and `x_ready` = 0.
- Counters: on acc to channel x, `x_cnt` ← `x_cnt` + 1 modulo 2^CNT_W, wrapping from all-ones to 0 silently.

## Timing
- Reset (`rst_n` low, asynchronous): both full flags = 0, `a_valid` = `b_valid` = 0, `a_data` = `b_data` = 0, counters = 0.
- While in reset, `in_ready` = 1 (both slots are empty). Inputs are ignored until the first rising edge after `rst_n` deasserts.
- Reset mid-operation: held words are discarded and valids drop immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N appears with `x_valid` = 1 from edge N onward, so it is visible in the cycle after acceptance. The earliest drain is at edge N+1.
- Throughput: 1 word/cycle per channel when the consumer holds ready = 1. The two channels alternate freely with no penalty.
- Full slot with its consumer stalled: `in_ready` = 0 whenever `in_sel` points at that slot, and `in_ready` = 1 when `in_sel` points at the other, empty slot.
- `in_valid` = 0: no state change except drains. `in_sel` and `in_data` are don't-care.

## Configuration
- `DEMUX2_CNT_EN` defined: the `a_cnt`/`b_cnt` ports and counter registers exist, with the behaviour above.
- Not defined: the counter ports and logic are omitted entirely. Datapath behaviour and timing are identical.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream with A full (`a_data` = 8'h5A) → `a_valid` = 0 and `a_data` = 0 immediately, before any clock edge. After release, `in_ready` = 1.
- Steering: send 8'h11 with sel 0, then 8'h22 with sel 1, both readys = 1 → A shows 8'h11 one cycle later, B shows 8'h22 the following cycle. Neither word appears on the wrong channel.
- Back-pressure isolation: hold `a_ready` = 0 and fill A with 8'h33 → with sel 0, `in_ready` = 0 and A holds 8'h33. With sel 1, 8'h44 is accepted and appears on B.
- Pass-through refill: A full with 8'h55, `a_ready` = 1, send 8'h66 with sel 0 in the same cycle → `in_ready` = 1. Next cycle `a_valid` = 1 and `a_data` = 8'h66, with no empty cycle.
- Streaming: 256 back-to-back words to B with `b_ready` = 1 → every word is observed in order, one per cycle. With `DEMUX2_CNT_EN` and `CNT_W` = 8, `b_cnt` wraps to 0 and `a_cnt` stays at 0.
- Random: random valid, sel and ready over 10k cycles → the scoreboard shows per-channel order preserved and no loss or duplication.

Source files
------------

// File: rtl/demux2_buf.sv
// demux2_buf: registered 1-to-2 demultiplexer with a one-entry valid/ready slot per channel
// Steers each accepted input word to channel A (in_sel = 0) or B (in_sel = 1).
// Each channel has its own slot, so a stalled consumer on one channel never blocks the other.
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  producer handshake; in_sel picks the channel, in_data is the word
//   a_valid/a_ready    channel A handshake, a_data is the registered word
//   b_valid/b_ready    channel B handshake, b_data is the registered word
//   a_cnt, b_cnt       per-channel accepted-word counters (only with DEMUX2_CNT_EN)
// Build option: define DEMUX2_CNT_EN to add the CNT_W parameter and the counter ports.
module demux2_buf #(
    parameter int WIDTH = 8
`ifdef DEMUX2_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready
`ifdef DEMUX2_CNT_EN
    , output logic [CNT_W-1:0] a_cnt
    , output logic [CNT_W-1:0] b_cnt
`endif
);
    logic acc_a, acc_b;
    // Only the selected slot gates in_ready; a full slot being drained this cycle can refill.
    always_comb begin
        in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready);
        acc_a    = in_valid & in_ready & ~in_sel;
        acc_b    = in_valid & in_ready & in_sel;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_data  <= '0;
            b_data  <= '0;
        end else begin
            if (acc_a) begin
                a_valid <= 1'b1;
                a_data  <= in_data;
            end else if (a_ready) begin
                a_valid <= 1'b0;
            end
            if (acc_b) begin
                b_valid <= 1'b1;
                b_data  <= in_data;
            end else if (b_ready) begin
                b_valid <= 1'b0;
            end
        end
    end
`ifdef DEMUX2_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (acc_a) a_cnt <= a_cnt + 1'b1;
            if (acc_b) b_cnt <= b_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf: directed and random self-checking bench for demux2_buf
module tb_demux2_buf;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_sel = 1'b0, in_ready;
    logic [7:0] in_data = 8'h00;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_ready = 1'b1, b_ready = 1'b1;
`ifdef DEMUX2_CNT_EN
    logic [7:0] a_cnt, b_cnt;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       exp_rdy;

    demux2_buf #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready)
`ifdef DEMUX2_CNT_EN
        , .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_a_data", 32'(a_data), 32'd0);
        check("rst_b_data", 32'(b_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // steering
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        #1 check("steer_rdy_a", 32'(in_ready), 32'd1);
        step();
        in_sel = 1'b1; in_data = 8'h22;
        #1;
        check("steer_a_valid", 32'(a_valid), 32'd1);
        check("steer_a_data", 32'(a_data), 32'h11);
        check("steer_b_empty", 32'(b_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("steer_b_valid", 32'(b_valid), 32'd1);
        check("steer_b_data", 32'(b_data), 32'h22);
        check("steer_a_drained", 32'(a_valid), 32'd0);
        step();
        check("steer_b_drained", 32'(b_valid), 32'd0);

        // back-pressure isolation
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33;
        step();
        in_data = 8'h99;
        #1;
        check("bp_rdy_sel_a", 32'(in_ready), 32'd0);
        check("bp_a_data", 32'(a_data), 32'h33);
        step();
        check("bp_a_hold_valid", 32'(a_valid), 32'd1);
        check("bp_a_hold_data", 32'(a_data), 32'h33);
        in_sel = 1'b1; in_data = 8'h44;
        #1 check("bp_rdy_sel_b", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_b_valid", 32'(b_valid), 32'd1);
        check("bp_b_data", 32'(b_data), 32'h44);
        check("bp_a_still", 32'(a_data), 32'h33);
        step();

        // pass-through refill
        a_ready = 1'b1;
        step();
        check("pt_a_empty", 32'(a_valid), 32'd0);
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
        step();
        check("pt_a_55", 32'(a_data), 32'h55);
        a_ready = 1'b1; in_data = 8'h66;
        #1 check("pt_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("pt_a_valid", 32'(a_valid), 32'd1);
        check("pt_a_data", 32'(a_data), 32'h66);
        step();
        check("pt_a_drained", 32'(a_valid), 32'd0);

        // asynchronous reset mid-stream
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        check("ar_a_5a", 32'(a_data), 32'h5A);
        #1 rst_n = 1'b0;
        #1;
        check("ar_a_valid", 32'(a_valid), 32'd0);
        check("ar_a_data", 32'(a_data), 32'd0);
        check("ar_rdy", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        a_ready = 1'b1;
        #1 check("ar_rdy_after", 32'(in_ready), 32'd1);
        step();

        // streaming 256 words to B
        b_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(i);
            #1 check("st_rdy", 32'(in_ready), 32'd1);
            step();
            check("st_b_valid", 32'(b_valid), 32'd1);
            check("st_b_data", 32'(b_data), 32'(i[7:0]));
        end
        in_valid = 1'b0;
        step();
        check("st_b_drained", 32'(b_valid), 32'd0);
`ifdef DEMUX2_CNT_EN
        check("st_b_cnt_wrap", 32'(b_cnt), 32'd0);
        check("st_a_cnt", 32'(a_cnt), 32'd0);
`endif

        // random traffic against a queue scoreboard (both slots empty here)
        for (int c = 0; c < 10000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            a_ready  = ($urandom_range(0, 9) < 7);
            b_ready  = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = in_sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
            check("rnd_rdy", 32'(in_ready), 32'(exp_rdy));
            check("rnd_a_valid", 32'(a_valid), 32'(qa.size() != 0));
            check("rnd_b_valid", 32'(b_valid), 32'(qb.size() != 0));
            if (qa.size() != 0) check("rnd_a_data", 32'(a_data), 32'(qa[0]));
            if (qb.size() != 0) check("rnd_b_data", 32'(b_data), 32'(qb[0]));
            if (qa.size() != 0 && a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && b_ready) void'(qb.pop_front());
            if (in_valid && exp_rdy) begin
                if (in_sel) qb.push_back(in_data);
                else qa.push_back(in_data);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
